// File: rtl/pc_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : pc_sequencer                                             |
// | Description : Instruction-fetch sequencer. Owns the PC, runs the imem  |
// |               req/ack handshake and resolves branch/jump redirects.    |
// |               Optional PC_SEQ_PERF_EN adds taken/discard counters.     |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module pc_sequencer #(
    parameter int unsigned     AW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               br_valid,
    input  logic [1:0]         BS,
    input  logic               PS,
    input  logic               Z,
    input  logic [AW-1:0]      BrA,
    input  logic [AW-1:0]      RAA,
    input  logic               stall,
    output logic               imem_req,
    output logic [AW-1:0]      imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_data,
    output logic               ir_valid,
    output logic [31:0]        instr,
    output logic [AW-1:0]      ir_pc,
    output logic [AW-1:0]      ir_pc1,
    output logic               flush
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [15:0]        taken_cnt,
    output logic [15:0]        discard_cnt
`endif
);

    localparam logic [1:0]    c_IDLE   = 2'd0;
    localparam logic [1:0]    c_FETCH  = 2'd1;
    localparam logic [1:0]    c_ISSUE  = 2'd2;
    localparam logic [AW-1:0] c_PC_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;

    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_fetch_addr;
    logic          r_discard;
    logic [31:0]   r_instr;
    logic [AW-1:0] r_ir_pc;
    logic [AW-1:0] r_ir_pc1;
    logic          r_flush;

    logic          w_taken;
    logic [AW-1:0] w_target;
    logic          w_ack_fetch;
    logic          w_drop;
    logic          w_capture;
    logic          w_load_fetch;
    logic [AW-1:0] w_fetch_src;
    logic [AW-1:0] w_fetch_inc;

    // ------------------------------------------------------------------
    // Branch resolution
    // ------------------------------------------------------------------
    assign w_taken  = br_valid & (BS[1] | ((BS == 2'b01) & (Z ^ PS)));
    assign w_target = (BS == 2'b11) ? RAA : BrA;

    // An ack is dropped if the fetch was already marked wrong-path or a
    // redirect lands in the very same cycle.
    assign w_ack_fetch = (r_state == c_FETCH) & imem_ack;
    assign w_drop      = w_ack_fetch & (r_discard | w_taken);
    assign w_capture   = w_ack_fetch & ~w_drop;
    assign w_fetch_inc = r_fetch_addr + c_PC_ONE;

    // A redirect seen in IDLE bypasses straight into the next fetch so the
    // very next request already targets the new PC.
    assign w_load_fetch = (r_state == c_IDLE) |
                          ((r_state == c_ISSUE) & ~stall & ~w_taken);
    assign w_fetch_src  = w_taken ? w_target : r_pc;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                w_state_nxt = c_FETCH;
            end
            c_FETCH: begin
                if (imem_ack) begin
                    w_state_nxt = w_drop ? c_IDLE : c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (w_taken) begin
                    w_state_nxt = c_IDLE;
                end else if (!stall) begin
                    w_state_nxt = c_FETCH;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        imem_req = 1'b0;
        ir_valid = 1'b0;
        case (r_state)
            c_FETCH: imem_req = 1'b1;
            c_ISSUE: ir_valid = 1'b1;
            default: begin
                imem_req = 1'b0;
                ir_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC, fetch address and issue registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_fetch_addr <= RESET_PC;
            r_discard    <= 1'b0;
            r_instr      <= 32'd0;
            r_ir_pc      <= '0;
            r_ir_pc1     <= c_PC_ONE;
            r_flush      <= 1'b0;
        end else begin
            r_flush <= w_taken;

            // Redirect outranks the sequential increment of a same-cycle ack.
            if (w_taken) begin
                r_pc <= w_target;
            end else if (w_capture) begin
                r_pc <= w_fetch_inc;
            end

            if (w_load_fetch) begin
                r_fetch_addr <= w_fetch_src;
            end

            // Only one fetch is ever outstanding, so any ack retires the flag.
            if (r_state == c_FETCH) begin
                if (imem_ack) begin
                    r_discard <= 1'b0;
                end else if (w_taken) begin
                    r_discard <= 1'b1;
                end
            end

            if (w_capture) begin
                r_instr  <= imem_data;
                r_ir_pc  <= r_fetch_addr;
                r_ir_pc1 <= w_fetch_inc;
            end
        end
    end

    assign imem_addr = r_fetch_addr;
    assign instr     = r_instr;
    assign ir_pc     = r_ir_pc;
    assign ir_pc1    = r_ir_pc1;
    assign flush     = r_flush;

    // ------------------------------------------------------------------
    // Performance counters (saturating)
    // ------------------------------------------------------------------
`ifdef PC_SEQ_PERF_EN
    logic [15:0] r_taken_cnt;
    logic [15:0] r_discard_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken_cnt   <= 16'd0;
            r_discard_cnt <= 16'd0;
        end else begin
            if (w_taken && (r_taken_cnt != 16'hFFFF)) begin
                r_taken_cnt <= r_taken_cnt + 16'd1;
            end
            if (w_drop && (r_discard_cnt != 16'hFFFF)) begin
                r_discard_cnt <= r_discard_cnt + 16'd1;
            end
        end
    end

    assign taken_cnt   = r_taken_cnt;
    assign discard_cnt = r_discard_cnt;
`else
    // Counters compiled out: no extra ports or state.
`endif

endmodule
`default_nettype wire
